bch_error_par: RTL and testbench
================================

BCH_ERROR_PAR -- requirements
Module: bch_error_par

Interface
REQ-001 SHALL have parameters: M, 4, field order (GF(2^M)); K, 5, data bits searched; T, 3, correction capability; P, 1, locations evaluated per beat (1..K).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  latch sigma and begin search; sigma  in  M*(T+1)  locator coefficients, sigma_i at [i*M+:M].
REQ-004 SHALL have ports: accepted  in  1  downstream takes current beat.
REQ-005 SHALL have ports: busy  out  1  search in progress; ready  out  1  first-beat pulse; valid  out  1  beat present.
REQ-006 SHALL have ports: last  out  1  final beat; err  out  P  error flags for the current beat.
REQ-007 SHALL have ports: err_count  out  clog2(T+2)  roots found so far; fail  out  1  uncorrectable flag.

Function
REQ-008 SHALL run states IDLE -> LOAD (one cycle) -> RUN -> IDLE.
REQ-009 SHALL sample start only in IDLE; start in LOAD or RUN SHALL be ignored.
REQ-010 SHALL, in LOAD, load register i with sigma_i·alpha^i; valid SHALL rise the cycle after LOAD (start at n -> valid at n+2); ready SHALL pulse exactly at n+2.
REQ-011 SHALL emit B = ceil(K/P) beats numbered b=0..B-1; err[p] in beat b SHALL be 1 iff sum_{i=0..T} sigma_i·alpha^(i·(b·P+p+1)) == 0 and b·P+p < K, else 0.
REQ-012 SHALL mask err lanes p with b·P+p >= K in the final beat to 0.
REQ-013 SHALL advance a beat only when valid && accepted; with accepted low, err, last, err_count and registers SHALL hold unchanged.
REQ-014 SHALL multiply register i by alpha^(i·P) per advance; err is combinational from registers, registered timing otherwise.
REQ-015 SHALL assert last with valid on beat B-1; on its acceptance, return to IDLE with valid, busy, last low the next cycle.
REQ-016 SHALL assert busy from the cycle after start through the cycle the last beat is accepted.
REQ-017 SHALL add popcount(err) to err_count on each accepted beat, saturating at 2^width-1; cleared in LOAD.
REQ-018 SHALL drive err to 0 whenever valid is low.

Reset
REQ-019 SHALL, on reset_n low, immediately clear busy, ready, valid, last, err, err_count, fail, state=IDLE, registers=0, regardless of state.
REQ-020 SHALL ignore start in the cycle reset_n deasserts; first accepted start is in the following cycle.

Configuration
REQ-021 SHALL, with BCH_ERROR_FAIL_EN defined, compute deg = highest i with sigma_i != 0 at LOAD and assert fail with last when the final err_count (including the last beat) != deg; fail holds until the next LOAD or reset.
REQ-022 SHALL, without BCH_ERROR_FAIL_EN, tie fail to 0 and omit degree logic.

Structure
REQ-023 SHALL place lpow(M,e) (alpha^e constant), beat-count B and err_count width functions in shared package bch_pkg.
REQ-024 SHALL use one sub-module chien_reg_par (one coefficient register: load, multiply-by-alpha^(i·P) step, P parallel alpha^(i·p) products), instantiated T+1 times.
REQ-025 SHALL reuse the existing parallel_standard_multiplier and finite_parallel_adder for GF products and sums.

Verification
REQ-026 M=4,K=5,T=3,P=2, sigma={0,0,0,1}, accepted=1 -> 3 beats, err=00 each, last on beat 2, err_count=0, fail=0.
REQ-027 Same params, sigma_0=1, sigma_1=alpha^11, others 0 -> beat 1 err=2'b10, other beats 00, err_count=1, fail=0.
REQ-028 Single-error case with accepted low 5 cycles during beat 1 -> err=2'b10 held all 5 cycles, err_count stays 0 until acceptance, then 1.
REQ-029 P=2,K=5 with root at position 5 (sigma_1=alpha^9) -> beat 2 lane 1 masked, err=00, err_count=0; BCH_ERROR_FAIL_EN: fail=1 with last.
REQ-030 reset_n low during beat 1 -> same cycle busy=valid=0, err_count=0; subsequent start runs normally from beat 0.
REQ-031 start pulsed during RUN -> ignored; beat sequence and err_count unaffected.

Source files
------------

// File: rtl/bch_pkg.sv
// Shared constants and helpers for the BCH Chien-search block.
// GF(2^M) uses a fixed primitive polynomial per field order, so every
// alpha power is folded into a constant at elaboration time.
package bch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_t;

  // Low-order terms of the primitive polynomial (the x^m term is implied)
  function automatic int prim_poly(input int m);
    case (m)
      2:       return 'h3;
      3:       return 'h3;
      4:       return 'h3;
      5:       return 'h5;
      6:       return 'h3;
      7:       return 'h3;
      8:       return 'h1D;
      default: return 'h3;
    endcase
  endfunction

  // alpha^e as an M-bit field element
  function automatic int lpow(input int m, input int e);
    int v;
    int n;
    int r;
    v = 1;
    n = (1 << m) - 1;
    r = e % n;
    for (int k = 0; k < r; k++) begin
      v = v << 1;
      if ((v & (1 << m)) != 0) begin
        v = (v ^ (1 << m)) ^ prim_poly(m);
      end
    end
    return v;
  endfunction

  // Number of beats needed to cover k positions, p per beat
  function automatic int beat_count(input int k, input int p);
    return (k + p - 1) / p;
  endfunction

  // Width of the root counter, wide enough to show one root beyond t
  function automatic int count_width(input int t);
    return $clog2(t + 2);
  endfunction

endpackage

// File: rtl/chien_reg_par.sv
// One Chien-search coefficient register for locator term IDX.
// Holds sigma_IDX * alpha^(IDX*(first position of the beat)); each lane p
// presents the term for position offset p within the beat.
module chien_reg_par
  import bch_pkg::*;
#(
  parameter int M   = 4,
  parameter int P   = 1,
  parameter int IDX = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [M-1:0] i_coeff,
  output logic [P*M-1:0] o_lanes
);

  localparam logic [M-1:0] LOAD_C = M'(lpow(M, IDX));
  localparam logic [M-1:0] STEP_C = M'(lpow(M, IDX * P));

  logic [M-1:0] r_val;
  logic [M-1:0] w_loaded;
  logic [M-1:0] w_stepped;

  parallel_standard_multiplier #(.M(M)) u_load (
    .i_a (i_coeff),
    .i_b (LOAD_C),
    .o_y (w_loaded)
  );

  parallel_standard_multiplier #(.M(M)) u_step (
    .i_a (r_val),
    .i_b (STEP_C),
    .o_y (w_stepped)
  );

  for (genvar p = 0; p < P; p++) begin : g_lane
    localparam logic [M-1:0] LANE_C = M'(lpow(M, IDX * p));
    parallel_standard_multiplier #(.M(M)) u_lane (
      .i_a (r_val),
      .i_b (LANE_C),
      .o_y (o_lanes[p*M +: M])
    );
  end

  // Load the first-position term, then advance by P positions per accepted beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_val <= '0;
    end else if (i_load) begin
      r_val <= w_loaded;
    end else if (i_step) begin
      r_val <= w_stepped;
    end
  end

endmodule

// File: rtl/finite_parallel_adder.sv
// Combinational GF(2^M) adder over N packed terms (bitwise XOR).
module finite_parallel_adder #(
  parameter int M = 4,
  parameter int N = 2
) (
  input  logic [N*M-1:0] i_terms,
  output logic [M-1:0]   o_sum
);

  // Field addition is XOR of all terms
  always_comb begin
    o_sum = '0;
    for (int n = 0; n < N; n++) begin
      o_sum = o_sum ^ i_terms[n*M +: M];
    end
  end

endmodule

// File: rtl/parallel_standard_multiplier.sv
// Combinational GF(2^M) multiplier in standard basis.
module parallel_standard_multiplier
  import bch_pkg::*;
#(
  parameter int M = 4
) (
  input  logic [M-1:0] i_a,
  input  logic [M-1:0] i_b,
  output logic [M-1:0] o_y
);

  localparam logic [M-1:0] POLY = M'(prim_poly(M));

  logic [M-1:0] w_acc;

  // Horner-style shift-and-add, reducing modulo the field polynomial each step
  always_comb begin
    w_acc = '0;
    for (int k = M - 1; k >= 0; k--) begin
      w_acc = {w_acc[M-2:0], 1'b0} ^ (w_acc[M-1] ? POLY : '0) ^ (i_b[k] ? i_a : '0);
    end
  end

  assign o_y = w_acc;

endmodule

// File: rtl/bch_error_par.sv
// Parallel Chien search: evaluates the error locator at positions 1..K,
// P positions per beat, flagging roots as error locations with a
// valid/accepted handshake and a running root count.
// Optional feature macro BCH_ERROR_FAIL_EN: compares the final root count
// against the locator degree and raises fail when they disagree.
module bch_error_par
  import bch_pkg::*;
#(
  parameter int M = 4,
  parameter int K = 5,
  parameter int T = 3,
  parameter int P = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [M*(T+1)-1:0]          sigma,
  input  logic                        accepted,
  output logic                        busy,
  output logic                        ready,
  output logic                        valid,
  output logic                        last,
  output logic [P-1:0]                err,
  output logic [count_width(T)-1:0]   err_count,
  output logic                        fail
);

  localparam int B  = beat_count(K, P);
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int CW = count_width(T);
  localparam int CMAX = (1 << CW) - 1;

  state_t          r_state;
  logic            r_armed;
  logic            r_busy;
  logic            r_ready;
  logic            r_valid;
  logic            r_last;
  logic [BW-1:0]   r_beat;
  logic [CW-1:0]   r_count;

  logic            w_load;
  logic            w_advance;
  logic [P*M-1:0]  w_lanes [T+1];
  logic [P-1:0]    w_root;
  logic [P-1:0]    w_mask;
  logic [CW-1:0]   w_next_count;

  assign w_load    = (r_state == ST_LOAD);
  assign w_advance = r_valid & accepted;

  for (genvar i = 0; i <= T; i++) begin : g_reg
    chien_reg_par #(.M(M), .P(P), .IDX(i)) u_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_load),
      .i_step  (w_advance),
      .i_coeff (sigma[i*M +: M]),
      .o_lanes (w_lanes[i])
    );
  end

  for (genvar p = 0; p < P; p++) begin : g_sum
    logic [(T+1)*M-1:0] w_terms;
    logic [M-1:0]       w_sum;
    for (genvar i = 0; i <= T; i++) begin : g_term
      assign w_terms[i*M +: M] = w_lanes[i][p*M +: M];
    end
    finite_parallel_adder #(.M(M), .N(T+1)) u_sum (
      .i_terms (w_terms),
      .o_sum   (w_sum)
    );
    assign w_root[p] = (w_sum == '0);
  end

  // Lanes past position K-1 (only possible in the final beat) never report
  always_comb begin
    w_mask = '0;
    for (int p = 0; p < P; p++) begin
      if (int'(r_beat) * P + p < K) begin
        w_mask[p] = 1'b1;
      end
    end
  end

  assign err = r_valid ? (w_root & w_mask) : '0;

  // Count after accepting the current beat, saturating at the counter maximum
  always_comb begin : p_count
    int v_sum;
    v_sum = int'(r_count);
    for (int p = 0; p < P; p++) begin
      v_sum = v_sum + int'(err[p]);
    end
    if (v_sum > CMAX) begin
      v_sum = CMAX;
    end
    w_next_count = CW'(v_sum);
  end

`ifdef BCH_ERROR_FAIL_EN
  logic [CW-1:0] w_deg;
  logic [CW-1:0] r_deg;
  logic          r_fail;

  // Locator degree is the highest non-zero coefficient index
  always_comb begin
    w_deg = '0;
    for (int i = 0; i <= T; i++) begin
      if (sigma[i*M +: M] != '0) begin
        w_deg = CW'(i);
      end
    end
  end

  assign fail = r_fail | (r_valid & r_last & (w_next_count != r_deg));
`else
  assign fail = 1'b0;
`endif

  // Search sequencer: start latch, one-cycle load, beat stepping and completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_beat  <= '0;
      r_count <= '0;
`ifdef BCH_ERROR_FAIL_EN
      r_deg   <= '0;
      r_fail  <= 1'b0;
`endif
    end else begin
      r_armed <= 1'b1;
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && r_armed) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_RUN;
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_beat  <= '0;
          r_last  <= (B == 1);
          r_count <= '0;
`ifdef BCH_ERROR_FAIL_EN
          r_deg   <= w_deg;
          r_fail  <= 1'b0;
`endif
        end
        ST_RUN: begin
          if (w_advance) begin
            r_count <= w_next_count;
            if (r_last) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
`ifdef BCH_ERROR_FAIL_EN
              r_fail  <= (w_next_count != r_deg);
`endif
            end else begin
              r_beat <= r_beat + 1'b1;
              r_last <= ((r_beat + 1'b1) == BW'(B - 1));
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign ready     = r_ready;
  assign valid     = r_valid;
  assign last      = r_last;
  assign err_count = r_count;

endmodule

// File: tb/tb_bch_error_par.sv
// Self-checking bench for bch_error_par (M=4, K=5, T=3, P=2).
// The reference model evaluates the locator polynomial directly at every
// position using GF(16) exponent/log arithmetic.
module tb_bch_error_par;

  localparam int M    = 4;
  localparam int K    = 5;
  localparam int T    = 3;
  localparam int P    = 2;
  localparam int SW   = M * (T + 1);
  localparam int B    = (K + P - 1) / P;
  localparam int CW   = 3;
  localparam int CMAX = 7;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start    = 1'b0;
  logic          accepted = 1'b0;
  logic [SW-1:0] sigma    = '0;
  logic          busy;
  logic          ready;
  logic          valid;
  logic          last;
  logic          fail;
  logic [P-1:0]  err;
  logic [CW-1:0] err_count;

  int nChecks = 0;
  int nFails  = 0;

  logic [P-1:0] expErr [B];
  int mBeat       = 0;
  int mCount      = 0;
  int mDeg        = 0;
  bit mActive     = 1'b0;
  bit mFirst      = 1'b0;
  bit mDone       = 1'b0;
  bit mFailSticky = 1'b0;

  bch_error_par #(.M(M), .K(K), .T(T), .P(P)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .sigma     (sigma),
    .accepted  (accepted),
    .busy      (busy),
    .ready     (ready),
    .valid     (valid),
    .last      (last),
    .err       (err),
    .err_count (err_count),
    .fail      (fail)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // alpha^k in GF(16) with x^4+x+1
  function automatic int gfExp(input int k);
    int v;
    v = 1;
    for (int n = 0; n < (k % 15); n++) begin
      v = v << 1;
      if (v >= 16) v = v ^ 'h13;
    end
    return v;
  endfunction

  function automatic int gfMul(input int a, input int b);
    int la;
    int lb;
    if (a == 0 || b == 0) return 0;
    la = 0;
    lb = 0;
    for (int k = 0; k < 15; k++) begin
      if (gfExp(k) == a) la = k;
      if (gfExp(k) == b) lb = k;
    end
    return gfExp(la + lb);
  endfunction

  // sigma(alpha^j)
  function automatic int locatorAt(input logic [SW-1:0] sig, input int j);
    int acc;
    acc = 0;
    for (int i = 0; i <= T; i++) begin
      acc = acc ^ gfMul(int'(sig[i*M +: M]), gfExp(i * j));
    end
    return acc;
  endfunction

  task automatic buildModel(input logic [SW-1:0] sig);
    for (int b = 0; b < B; b++) begin
      for (int p = 0; p < P; p++) begin
        expErr[b][p] = ((b * P + p) < K) && (locatorAt(sig, b * P + p + 1) == 0);
      end
    end
    mDeg = 0;
    for (int i = 0; i <= T; i++) begin
      if (sig[i*M +: M] != '0) mDeg = i;
    end
  endtask

  // Compare DUT against the model every cycle, then track accepted beats
  always @(negedge clk) begin : compare
    logic [P-1:0] e;
    int fin;
    bit ef;
    if (mActive) begin
      e   = expErr[mBeat];
      fin = mCount + $countones(e);
      if (fin > CMAX) fin = CMAX;
`ifdef BCH_ERROR_FAIL_EN
      ef = mFailSticky || ((mBeat == B - 1) && (fin != mDeg));
`else
      ef = 1'b0;
`endif
      checkOutput("valid", int'(valid), 1);
      checkOutput("err", int'(err), int'(e));
      checkOutput("last", int'(last), int'(mBeat == B - 1));
      checkOutput("err_count", int'(err_count), mCount);
      checkOutput("busy", int'(busy), 1);
      checkOutput("ready", int'(ready), int'(mFirst));
      checkOutput("fail", int'(fail), int'(ef));
      mFirst = 1'b0;
      if (accepted) begin
        mCount = fin;
        if (mBeat == B - 1) begin
          mActive     = 1'b0;
          mDone       = 1'b1;
          mFailSticky = ef;
        end else begin
          mBeat++;
        end
      end
    end else begin
      checkOutput("idleValid", int'(valid), 0);
      checkOutput("idleErr", int'(err), 0);
      checkOutput("idleReady", int'(ready), 0);
      checkOutput("idleLast", int'(last), 0);
`ifdef BCH_ERROR_FAIL_EN
      checkOutput("idleFail", int'(fail), int'(mFailSticky));
`else
      checkOutput("idleFail", int'(fail), 0);
`endif
    end
  end

  // Release reset with start already high; the first edge must not take it
  task automatic releaseReset();
    reset_n = 1'b1;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("startIgnoredAfterReset", int'(busy), 0);
  endtask

  // One search run; called and returns at 1 time unit after a rising edge
  task automatic applyStimulus(input string tag, input logic [SW-1:0] sig,
                               input int expCount, input bit expFailLit,
                               input int stallBeat, input int stallCycles,
                               input logic [P-1:0] stallErrLit,
                               input int pulseBeat, input int resetBeat);
    int stallLeft;
    int cycles;
    bit pulsed;
    sigma = sig;
    buildModel(sig);
    start    = 1'b1;
    accepted = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, "_busyAfterStart"}, int'(busy), 1);
    checkOutput({tag, "_validInLoad"}, int'(valid), 0);
    @(posedge clk); #1;
    mBeat       = 0;
    mCount      = 0;
    mDone       = 1'b0;
    mFirst      = 1'b1;
    mFailSticky = 1'b0;
    mActive     = 1'b1;
    stallLeft   = stallCycles;
    cycles      = 0;
    pulsed      = 1'b0;
    while (!mDone && cycles < 40) begin
      if (mActive && mBeat == resetBeat) begin
        reset_n  = 1'b0;
        accepted = 1'b0;
        start    = 1'b0;
        #1;
        checkOutput({tag, "_rstBusy"}, int'(busy), 0);
        checkOutput({tag, "_rstValid"}, int'(valid), 0);
        checkOutput({tag, "_rstCount"}, int'(err_count), 0);
        checkOutput({tag, "_rstErr"}, int'(err), 0);
        mActive     = 1'b0;
        mFailSticky = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        releaseReset();
        return;
      end
      if (mBeat == pulseBeat && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (mBeat == stallBeat && stallLeft > 0) begin
        accepted = 1'b0;
        stallLeft--;
        checkOutput({tag, "_heldErr"}, int'(err), int'(stallErrLit));
      end else begin
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start    = 1'b0;
    accepted = 1'b0;
    if (!mDone) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s_timeout: actual=no completion required=completion within 40 cycles", tag);
      mActive = 1'b0;
    end
    checkOutput({tag, "_doneBusy"}, int'(busy), 0);
    checkOutput({tag, "_doneValid"}, int'(valid), 0);
    checkOutput({tag, "_doneLast"}, int'(last), 0);
    checkOutput({tag, "_finalCount"}, int'(err_count), expCount);
`ifdef BCH_ERROR_FAIL_EN
    checkOutput({tag, "_finalFail"}, int'(fail), int'(expFailLit));
`else
    checkOutput({tag, "_finalFail"}, int'(fail), 0);
`endif
  endtask

  initial begin
    #1;
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstReady", int'(ready), 0);
    checkOutput("rstValid", int'(valid), 0);
    checkOutput("rstLast", int'(last), 0);
    checkOutput("rstErr", int'(err), 0);
    checkOutput("rstCount", int'(err_count), 0);
    checkOutput("rstFail", int'(fail), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    releaseReset();

    // sigma_0=1 only: never zero
    applyStimulus("noRoots", 16'h0001, 0, 1'b0, -1, 0, 2'b00, -1, -1);
    // 1 + alpha^11 x: root at position 4 -> beat 1 lane 1
    applyStimulus("oneRoot", 16'h00E1, 1, 1'b0, -1, 0, 2'b00, -1, -1);
    // Same locator, downstream stalls 5 cycles on beat 1
    applyStimulus("stall", 16'h00E1, 1, 1'b0, 1, 5, 2'b10, -1, -1);
    // 1 + alpha^9 x: root at position 6 lies beyond K and is masked
    applyStimulus("masked", 16'h00A1, 0, 1'b1, -1, 0, 2'b00, -1, -1);
    // alpha^4 + alpha^9 x + x^2: roots at positions 1 and 3, stall on beat 0
    applyStimulus("twoRoots", 16'h01A3, 2, 1'b0, 0, 2, 2'b01, -1, -1);
    // Reset during beat 1, then a clean run
    applyStimulus("resetMid", 16'h00E1, 0, 1'b0, -1, 0, 2'b00, -1, 1);
    applyStimulus("afterReset", 16'h00E1, 1, 1'b0, -1, 0, 2'b00, -1, -1);
    // Start pulse in the middle of a run must not disturb it
    applyStimulus("startInRun", 16'h00E1, 1, 1'b0, -1, 0, 2'b00, 1, -1);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
